// File: rtl/i2c_transaction_scheduler.sv
// Two-requester I2C burst scheduler: round-robin arbitration, START/BIT/ACK/STOP sequencing
// and index-counter control. Counter wrap flags come back in through last_bit/msg/trans.
module i2c_transaction_scheduler (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_tick,
    input  logic [1:0] req,
    input  logic [1:0] msg_lim0,
    input  logic [1:0] msg_lim1,
    input  logic [4:0] trans_lim0,
    input  logic [4:0] trans_lim1,
    input  logic       last_bit,
    input  logic       last_msg,
    input  logic       last_trans,
    input  logic       nack,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       inc_bit,
    output logic       inc_msg,
    output logic       inc_trans,
    output logic       cnt_clear,
    output logic [2:0] LIMIT_BIT,
    output logic [1:0] LIMIT_MSG,
    output logic [4:0] LIMIT_TRANS,
    output logic       start_cond,
    output logic       ack_slot,
    output logic       stop_cond,
    output logic       busy
);

    typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop} state_t;

    state_t     state_q;
    logic [1:0] grant_q;
    logic       ptr_q;
    logic       err_flag_q;
    logic [1:0] lim_msg_q;
    logic [4:0] lim_trans_q;
    logic       win;
    logic       stop_tick;

    // Pointer only matters when both request; a lone requester always wins.
    always_comb win = (req == 2'b11) ? ptr_q : req[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= 2'b00;
            ptr_q       <= 1'b0;
            err_flag_q  <= 1'b0;
            lim_msg_q   <= 2'd0;
            lim_trans_q <= 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req != 2'b00) begin
                        grant_q     <= win ? 2'b10 : 2'b01;
                        ptr_q       <= ~win;
                        lim_msg_q   <= win ? msg_lim1 : msg_lim0;
                        lim_trans_q <= win ? trans_lim1 : trans_lim0;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (bit_tick) state_q <= StBit;
                end
                StBit: begin
                    if (bit_tick && last_bit) state_q <= StAck;
                end
                StAck: begin
                    if (bit_tick) begin
                        if (nack) begin
                            err_flag_q <= 1'b1;
                            state_q    <= StStop;
                        end else if (last_msg) begin
                            state_q <= last_trans ? StStop : StStart;
                        end else begin
                            state_q <= StBit;
                        end
                    end
                end
                StStop: begin
                    if (bit_tick) begin
                        grant_q    <= 2'b00;
                        err_flag_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stop_tick = bit_tick && (state_q == StStop);
        inc_bit   = bit_tick && (state_q == StBit);
        inc_msg   = bit_tick && (state_q == StAck) && !nack;
        inc_trans = inc_msg && last_msg;
        // Counters are held cleared for the whole reset as well as at burst end.
        cnt_clear = !reset || stop_tick;
        done      = stop_tick ? grant_q : 2'b00;
        err       = (stop_tick && err_flag_q) ? grant_q : 2'b00;
    end

    assign grant       = grant_q;
    assign LIMIT_BIT   = 3'd7;
    assign LIMIT_MSG   = lim_msg_q;
    assign LIMIT_TRANS = lim_trans_q;
    assign start_cond  = (state_q == StStart);
    assign ack_slot    = (state_q == StAck);
    assign stop_cond   = (state_q == StStop);
    assign busy        = (state_q != StIdle);

endmodule
